// File: rtl/serdes_pkg.sv
// Shared definitions for the LSTM accelerator serializer/deserializer pair.
// Default geometry, FSM state type and element type.
package serdes_pkg;

    localparam int ELEMENT_BITS = 8;
    localparam int FEATURES     = 4;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} ser_state_t;

    typedef logic [ELEMENT_BITS-1:0] element_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N up-counter with synchronous clear, count enable and terminal-count flag.
module wrap_counter #(
    parameter int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         enable_i,
    output logic [W-1:0] count_o,
    output logic         terminal_o
);

    logic [W-1:0] count_q;

    assign terminal_o = (count_q == W'(N - 1));
    assign count_o    = count_q;

    // Clear has priority over enable so a fresh capture always starts at index 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= terminal_o ? '0 : count_q + W'(1);
        end
    end

endmodule

// File: rtl/lstm_serializer.sv
// Streams two captured feature vectors (vec1 then vec2, element 0 first) over a
// valid/ready serial bus, with a one-cycle done pulse after the last element.
module lstm_serializer
    import serdes_pkg::*;
#(
    parameter int ELEMENT_BITS = serdes_pkg::ELEMENT_BITS,
    parameter int FEATURES     = serdes_pkg::FEATURES
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [ELEMENT_BITS*FEATURES-1:0] parallel_data_in_1,
    input  logic [ELEMENT_BITS*FEATURES-1:0] parallel_data_in_2,
    input  logic                             serial_ready,
    output logic                             serial_valid,
    output logic [ELEMENT_BITS-1:0]          serial_data_out,
    output logic                             busy,
    output logic                             done
);

    localparam int DEPTH = 2 * FEATURES;
    localparam int CW    = $clog2(DEPTH);

    ser_state_t              state_q;
    logic [ELEMENT_BITS-1:0] shadow_q [DEPTH];
    logic                    valid_q;
    logic [ELEMENT_BITS-1:0] data_q;
    logic                    busy_q;
    logic                    done_q;

    logic          handshake;
    logic          counterClear;
    logic [CW-1:0] elemIdx;
    logic [CW-1:0] nextIdx;
    logic          atTerminal;

    assign handshake    = valid_q & serial_ready;
    assign counterClear = (state_q == IDLE) & start;
    assign nextIdx      = elemIdx + CW'(1);

    wrap_counter #(
        .N (DEPTH)
    ) u_elem_counter (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (counterClear),
        .enable_i   (handshake),
        .count_o    (elemIdx),
        .terminal_o (atTerminal)
    );

    // Output data is registered one element ahead: on each handshake the next
    // shadow entry is loaded so serial_data_out always matches the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        for (int k = 0; k < FEATURES; k++) begin
                            shadow_q[k]          <= parallel_data_in_1[k*ELEMENT_BITS +: ELEMENT_BITS];
                            shadow_q[FEATURES+k] <= parallel_data_in_2[k*ELEMENT_BITS +: ELEMENT_BITS];
                        end
                        data_q  <= parallel_data_in_1[ELEMENT_BITS-1:0];
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (handshake) begin
                        if (atTerminal) begin
                            valid_q <= 1'b0;
                            data_q  <= '0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            data_q <= shadow_q[nextIdx];
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign serial_valid    = valid_q;
    assign serial_data_out = data_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule
